sw_ctrl: RTL
============

SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count-tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, >=2.
REQ-003 SHALL have parameter DEB_CYCLES, default 1_000_000, debounce stability window in clk cycles.
REQ-004 SHALL have port clk  in  1  system clock, one clock for the whole block.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports start, stop, split  in  1 each  raw asynchronous button levels, active-high.
REQ-007 SHALL have port tick  out  1  one-cycle count pulse at TICK_HZ while counting.
REQ-008 SHALL have port cnt_en  out  1  level; high in RUN and SPLIT.
REQ-009 SHALL have port cnt_clr  out  1  one-cycle pulse commanding the time counter to zero.
REQ-010 SHALL have port disp_latch  out  1  one-cycle pulse capturing the count into the display register.
REQ-011 SHALL have port disp_hold  out  1  level; display shows the latched value, not the live count.
REQ-012 SHALL have port state  out  2  current state: IDLE=0, RUN=1, SPLIT=2, STOP=3.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a rising-edge detector giving a one-cycle event.
REQ-014 Without debounce, state SHALL change on the 3rd rising clk edge after the raw input is first sampled high.
REQ-015 Simultaneous events SHALL resolve by priority stop > start > split; lower-priority events that cycle are dropped.
REQ-016 IDLE: start -> RUN, with cnt_clr pulse in the transition cycle; stop and split ignored.
REQ-017 RUN: stop -> STOP; split -> SPLIT, with disp_latch pulse; start ignored.
REQ-018 SPLIT: split -> RUN; stop -> STOP; start ignored; counting continues throughout SPLIT.
REQ-019 STOP: start -> RUN, resuming without clear; split -> IDLE, with cnt_clr pulse; stop ignored.
REQ-020 disp_hold SHALL be 1 exactly while state==SPLIT; cnt_en SHALL be 1 exactly while state is RUN or SPLIT.
REQ-021 Prescaler SHALL count 0..DIV-1 only while cnt_en=1, hold its value in STOP, and return to 0 on cnt_clr.
REQ-022 tick SHALL pulse for one cycle when the prescaler wraps from DIV-1 to 0; never while cnt_en=0.
REQ-023 The first tick after a cleared start SHALL occur DIV cycles after entry to RUN.
REQ-024 Prescaler width SHALL be $clog2(DIV); no overflow for any legal DIV.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, prescaler=0, synchronizers/edge/debounce regs=0, and all outputs 0.
REQ-027 Reset mid-RUN or mid-SPLIT SHALL drop any pending event; no cnt_clr is emitted on reset release.
REQ-028 A button held high through reset release SHALL NOT generate an event until released and pressed again.

Configuration
REQ-029 With SW_CTRL_DEBOUNCE_EN defined, each synchronized input SHALL become its stable value only after DEB_CYCLES consecutive equal samples, then be edge-detected.
REQ-030 Without SW_CTRL_DEBOUNCE_EN, the debounce counters SHALL be absent and REQ-014 latency SHALL apply.

Structure
REQ-031 Package sw_pkg SHALL hold the state enum (IDLE, RUN, SPLIT, STOP) and the event priority encoding.
REQ-032 Sub-module sw_btn_cond SHALL implement synchronizer, optional debounce and edge detect; instantiated three times.

Verification
REQ-033 Use CLK_HZ=1000 and TICK_HZ=100 (DIV=10); without debounce: start pulse -> state 0->1, one cnt_clr, first tick 10 cycles after RUN entry, then every 10 cycles.
REQ-034 RUN, split -> state=2, one disp_latch, disp_hold=1, ticks continue; split again -> state=1, disp_hold=0.
REQ-035 RUN for 7 cycles past a tick, stop -> state=3, no ticks; start -> first tick 3 cycles after RUN re-entry; STOP, split -> IDLE plus cnt_clr.
REQ-036 In RUN, start+stop+split raised on the same cycle -> STOP only; no disp_latch.
REQ-037 Assert rst low in SPLIT with stop held -> all outputs 0 at once; release with stop still held -> state stays 0.
REQ-038 With SW_CTRL_DEBOUNCE_EN and DEB_CYCLES=5: 3-cycle glitch on start -> no event; 8-cycle press -> RUN exactly once.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg -- shared types for the stopwatch controller.
// Holds the controller state encoding, the button index map and the
// priority encoder that turns simultaneous button events into one event.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SPLIT = 2'd2,
    STOP  = 2'd3
  } sw_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_STOP  = 2'd1,
    EV_START = 2'd2,
    EV_SPLIT = 2'd3
  } sw_evt_e;

  // Bit positions of the buttons inside the conditioned-event vector
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;
  localparam int unsigned BTN_SPLIT = 2;
  localparam int unsigned N_BTN     = 3;

  // stop beats start beats split; whatever loses in a cycle is discarded
  function automatic sw_evt_e sw_resolve(input logic [N_BTN-1:0] ev);
    sw_evt_e res;
    res = EV_NONE;
    if (ev[BTN_STOP])       res = EV_STOP;
    else if (ev[BTN_START]) res = EV_START;
    else if (ev[BTN_SPLIT]) res = EV_SPLIT;
    return res;
  endfunction

endpackage

// File: rtl/sw_btn_cond.sv
// sw_btn_cond -- conditions one raw push-button level into a one-cycle event.
// Path: 2-FF synchronizer -> optional debounce -> rising-edge detector.
// Build option: define SW_CTRL_DEBOUNCE_EN to insert the DEB_CYCLES stability
// filter; without it the event fires on the third clock edge after the raw
// level is first sampled high.
module sw_btn_cond #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_evt
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("sw_btn_cond: DEB_CYCLES must be at least 1");
  end

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_warm;
  logic       w_level;

  // Two-stage synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Arm the detector only once the synchronized level has been seen low after
  // reset, so a button held through reset release cannot fake a press. r_warm
  // waits until r_sync2 carries a real sample rather than its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      if (r_warm == 2'd2 && !r_sync2) r_armed <= 1'b1;
    end
  end

`ifdef SW_CTRL_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_stable;
  logic [DEB_W-1:0] r_deb_cnt;

  // Adopt a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_stable  <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  // Previous level for the rising-edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= w_level;
  end

  assign o_evt = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl -- stopwatch control FSM with tick prescaler.
// Three conditioned buttons drive an IDLE/RUN/SPLIT/STOP machine; the
// prescaler emits one tick every CLK_HZ/TICK_HZ cycles while counting.
// Build option: SW_CTRL_DEBOUNCE_EN enables the per-button debounce filter.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       split,
  output logic       tick,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_latch,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
    $error("sw_ctrl: CLK_HZ/TICK_HZ must be an integer of at least 2");
  end

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] w_btn_ev;
  sw_evt_e          w_evt;

  sw_state_e        r_state;
  sw_state_e        w_state_next;

  logic             w_en_next;
  logic             w_hold_next;
  logic             w_clr_next;
  logic             w_latch_next;

  logic             r_cnt_en;
  logic             r_cnt_clr;
  logic             r_disp_latch;
  logic             r_disp_hold;

  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             w_presc_adv;

  assign w_btn_raw[BTN_START] = start;
  assign w_btn_raw[BTN_STOP]  = stop;
  assign w_btn_raw[BTN_SPLIT] = split;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    sw_btn_cond #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .i_btn (w_btn_raw[gi]),
      .o_evt (w_btn_ev[gi])
    );
  end

  assign w_evt = sw_resolve(w_btn_ev);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode from the single resolved event
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_evt == EV_START) w_state_next = RUN;
      RUN: begin
        if (w_evt == EV_STOP)       w_state_next = STOP;
        else if (w_evt == EV_SPLIT) w_state_next = SPLIT;
      end
      SPLIT: begin
        if (w_evt == EV_STOP)       w_state_next = STOP;
        else if (w_evt == EV_SPLIT) w_state_next = RUN;
      end
      STOP: begin
        if (w_evt == EV_START)      w_state_next = RUN;
        else if (w_evt == EV_SPLIT) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: levels follow the next state, pulses mark transitions
  always_comb begin
    w_en_next    = (w_state_next == RUN) || (w_state_next == SPLIT);
    w_hold_next  = (w_state_next == SPLIT);
    w_clr_next   = ((r_state == IDLE) && (w_state_next == RUN)) ||
                   ((r_state == STOP) && (w_state_next == IDLE));
    w_latch_next = (r_state == RUN) && (w_state_next == SPLIT);
  end

  // Output registers, updated on the same edge as the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_en     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      r_disp_latch <= 1'b0;
      r_disp_hold  <= 1'b0;
    end else begin
      r_cnt_en     <= w_en_next;
      r_cnt_clr    <= w_clr_next;
      r_disp_latch <= w_latch_next;
      r_disp_hold  <= w_hold_next;
    end
  end

  // Advance while counting. If counting stops on the very edge the prescaler
  // would wrap, hold at DIV-1 instead so the tick is issued on resume rather
  // than lost or emitted while cnt_en is low.
  assign w_presc_adv = r_cnt_en && (w_en_next || (r_presc != P_LAST));

  // Prescaler and tick; clearing happens on the edge cnt_clr is raised so the
  // first tick lands DIV cycles after entering RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_clr_next) begin
        r_presc <= '0;
      end else if (w_presc_adv) begin
        if (r_presc == P_LAST) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign state      = r_state;
  assign tick       = r_tick;
  assign cnt_en     = r_cnt_en;
  assign cnt_clr    = r_cnt_clr;
  assign disp_latch = r_disp_latch;
  assign disp_hold  = r_disp_hold;

endmodule
